// File: rtl/arb_pkt_pkg.sv
// Shared types for the packet mux that sits behind the round-robin arbiter.
// beat_t is fixed at PKT_DATA_W; the top's DATA_WIDTH must match it.
package arb_pkt_pkg;

    localparam int PKT_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [PKT_DATA_W-1:0] data;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/arb_pkt_out_reg.sv
// Single-entry valid/ready pipeline register; 1 cycle latency, full throughput.
// Accepts a new entry whenever it is empty or the current one leaves this cycle.
module arb_pkt_out_reg #(
    parameter int W = 33
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_dat,
    input  logic         i_rdy
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    assign o_rdy = !r_vld || i_rdy;
    assign o_vld = r_vld;
    assign o_dat = r_dat;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (o_rdy) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= i_dat;
            end
        end
    end

endmodule

// File: rtl/arb_packet_mux.sv
// Packet mux behind a round-robin arbiter: holds a grant for a whole packet, 1 cycle to v_o.
// Per-channel ready follows the output register; the arbiter only sees requests while idle.
module arb_packet_mux
    import arb_pkt_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH     = PKT_DATA_W,
    parameter int MAX_BEATS      = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [NUM_REQUESTERS-1:0]           v_i,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] data_i,
    input  logic [NUM_REQUESTERS-1:0]           last_i,
    output logic [NUM_REQUESTERS-1:0]           ready_o,
    output logic [NUM_REQUESTERS-1:0]           reqs_o,
    input  logic [NUM_REQUESTERS-1:0]           grants_i,
    output logic                                yumi_o,
    output logic                                v_o,
    output logic [DATA_WIDTH-1:0]               data_o,
    output logic                                last_o,
    input  logic                                ready_i,
    output logic                                err_o
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    state_e                    r_state, w_state_nxt;
    logic [NUM_REQUESTERS-1:0] r_lock, w_lock_nxt;
    logic [CW-1:0]             r_beat_cnt, w_beat_cnt_nxt;
    logic                      r_err, w_err_nxt;

    logic                      w_out_rdy;
    logic                      w_acc;
    logic                      w_force_last;
    logic                      w_at_max;
    logic [DATA_WIDTH-1:0]     w_sel_data;
    logic                      w_sel_last;
    beat_t                     w_in_beat;
    beat_t                     w_out_beat;

    // lock is one-hot or zero, so an OR-reduce mux picks the locked channel.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (r_lock[k]) begin
                w_sel_data = w_sel_data | data_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last = w_sel_last | last_i[k];
            end
        end
    end

    assign w_at_max = (r_beat_cnt == CW'(MAX_BEATS - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_nxt     = r_lock;
        w_beat_cnt_nxt = r_beat_cnt;
        w_err_nxt      = r_err;
        reqs_o         = '0;
        ready_o        = '0;
        yumi_o         = 1'b0;
        w_acc          = 1'b0;
        w_force_last   = 1'b0;
        case (r_state)
            IDLE: begin
                // Requests are masked during reset so the arbiter sees nothing mid-reset.
                reqs_o = reset_i ? '0 : v_i;
                if (grants_i != '0) begin
                    if ($onehot(grants_i) && ((grants_i & v_i) != '0)) begin
                        w_state_nxt = BUSY;
                        w_lock_nxt  = grants_i;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            BUSY: begin
                ready_o = r_lock & {NUM_REQUESTERS{w_out_rdy}};
                w_acc   = |(v_i & ready_o);
                if (w_acc) begin
                    w_beat_cnt_nxt = (r_beat_cnt == CW'(MAX_BEATS)) ? r_beat_cnt
                                                                    : r_beat_cnt + 1'b1;
                    if (w_sel_last || w_at_max) begin
                        yumi_o         = 1'b1;
                        w_state_nxt    = IDLE;
                        w_lock_nxt     = '0;
                        w_beat_cnt_nxt = '0;
                    end
                    if (!w_sel_last && w_at_max) begin
                        w_err_nxt    = 1'b1;
                        w_force_last = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_lock     <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock     <= w_lock_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign w_in_beat.data = w_sel_data;
    assign w_in_beat.last = w_sel_last | w_force_last;

    arb_pkt_out_reg #(
        .W($bits(beat_t))
    ) u_out_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_vld   (w_acc),
        .i_dat   (w_in_beat),
        .o_rdy   (w_out_rdy),
        .o_vld   (v_o),
        .o_dat   (w_out_beat),
        .i_rdy   (ready_i)
    );

    assign data_o = w_out_beat.data;
    assign last_o = w_out_beat.last;
    assign err_o  = r_err;

endmodule

// File: tb/tb_arb_packet_mux.sv
// Randomized and directed bench for arb_packet_mux against a queue-based reference model.
module tb_arb_packet_mux;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 16;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [N-1:0]    v_i, last_i, ready_o, reqs_o, grants_i;
    logic [N*DW-1:0] data_i;
    logic            yumi_o, v_o, last_o, ready_i, err_o;
    logic [DW-1:0]   data_o;

    always #5 clk_i = ~clk_i;

    arb_packet_mux #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .last_i(last_i),
        .ready_o(ready_o), .reqs_o(reqs_o), .grants_i(grants_i), .yumi_o(yumi_o),
        .v_o(v_o), .data_o(data_o), .last_o(last_o), .ready_i(ready_i), .err_o(err_o)
    );

    typedef struct { logic [DW-1:0] d; logic l; } beat_s;
    typedef struct { int cyc; logic [DW-1:0] d; logic l; } rx_s;

    beat_s srcq[N][$];
    beat_s m_outq[$];
    rx_s   rx[$];
    int    n_chk = 0, n_pass = 0, n_fail = 0;
    int    cyc = 0, yumi_cnt = 0, arb_last = N - 1;
    bit    m_busy = 0, m_err = 0;
    int    m_ch = 0, m_cnt = 0;
    int    gmode = 0, gsel = 0;
    logic [N-1:0] graw = '0;
    bit    gaps = 0, rnd_rdy = 0, rdy_val = 1;
    int    sent = 0, t0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [N-1:0] rr_grant(logic [N-1:0] reqs, int last);
        logic [N-1:0] g = '0;
        for (int i = 1; i <= N; i++) begin
            int idx = (last + i) % N;
            if (reqs[idx] && g == '0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    task automatic push_pkt(int ch, int len, logic [DW-1:0] base, bit rnd);
        for (int i = 0; i < len; i++) begin
            beat_s b;
            b.d = rnd ? DW'($urandom) : base + DW'(i);
            b.l = (i == len - 1);
            srcq[ch].push_back(b);
        end
        sent += len;
    endtask

    // One clock: drive inputs, compare at negedge, advance the model after posedge.
    task automatic step();
        logic [N-1:0] e_reqs, e_rdy, g;
        bit rdy_out, acc, lst, trunc, yum;
        beat_s hb;
        for (int k = 0; k < N; k++) begin
            if (srcq[k].size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
                v_i[k] = 1'b1;
                data_i[k*DW +: DW] = srcq[k][0].d;
                last_i[k] = srcq[k][0].l;
            end else begin
                v_i[k] = 1'b0;
                last_i[k] = 1'b0;
            end
        end
        ready_i = rnd_rdy ? ($urandom_range(0, 2) != 0) : rdy_val;
        #1;
        case (gmode)
            0:       grants_i = v_i[gsel] ? (N'(1) << gsel) : '0;
            1:       grants_i = rr_grant(reqs_o, arb_last);
            default: grants_i = graw;
        endcase
        @(negedge clk_i);
        e_reqs  = m_busy ? '0 : v_i;
        rdy_out = (m_outq.size() == 0) || ready_i;
        e_rdy   = '0;
        acc = 0;
        lst = 0;
        if (m_busy && rdy_out) begin
            e_rdy[m_ch] = 1'b1;
            acc = v_i[m_ch];
            lst = last_i[m_ch];
        end
        trunc = acc && !lst && (m_cnt + 1 == MB);
        yum   = acc && (lst || (m_cnt + 1 == MB));
        chk("v_o", v_o, m_outq.size() != 0);
        if (m_outq.size() != 0) begin
            chk("data_o", data_o, m_outq[0].d);
            chk("last_o", last_o, m_outq[0].l);
        end
        chk("err_o", err_o, m_err);
        chk("ready_o", ready_o, e_rdy);
        chk("reqs_o", reqs_o, e_reqs);
        chk("yumi_o", yumi_o, yum);
        if (v_o && ready_i) rx.push_back('{cyc, data_o, last_o});
        if (yumi_o) yumi_cnt++;
        g = grants_i;
        @(posedge clk_i);
        if (rdy_out && m_outq.size() != 0) void'(m_outq.pop_front());
        if (acc) begin
            hb = srcq[m_ch].pop_front();
            hb.l = hb.l | trunc;
            m_outq.push_back(hb);
        end
        if (!m_busy) begin
            if (g != '0) begin
                if ($countones(g) == 1 && (g & v_i) != '0) begin
                    m_busy = 1;
                    m_cnt  = 0;
                    for (int k = 0; k < N; k++) if (g[k]) m_ch = k;
                end else m_err = 1;
            end
        end else if (acc) begin
            m_cnt++;
            if (trunc) m_err = 1;
            if (yum) begin
                m_busy = 0;
                m_cnt = 0;
                arb_last = m_ch;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        for (int k = 0; k < N; k++) srcq[k].delete();
        m_outq.delete();
        m_busy = 0; m_err = 0; m_cnt = 0; m_ch = 0; arb_last = N - 1;
        v_i = '0; last_i = '0; data_i = '0; grants_i = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    task automatic new_test();
        rx.delete();
        yumi_cnt = 0;
        gaps = 0; rnd_rdy = 0; rdy_val = 1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit drained;
        reset_i = 1'b1; v_i = '1; data_i = '0; last_i = '0; grants_i = '0; ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_v_o", v_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_ready_o", ready_o, 0);
        chk("rst_reqs_o", reqs_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_yumi_o", yumi_o, 0);
        reset_i = 1'b0; v_i = '0;

        // Single 3-beat packet on channel 2.
        new_test(); gmode = 0; gsel = 2;
        push_pkt(2, 3, 32'hA0, 0);
        t0 = cyc;
        run(8);
        chk("t1_nbeats", rx.size(), 3);
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            chk("t1_cycle", rx[i].cyc, t0 + 2 + i);
            chk("t1_data", rx[i].d, 32'hA0 + i);
            chk("t1_last", rx[i].l, i == 2);
        end
        chk("t1_yumi_cnt", yumi_cnt, 1);

        // Downstream stall mid-packet.
        new_test(); gmode = 0; gsel = 0;
        push_pkt(0, 6, 32'hB0, 0);
        run(4);
        rdy_val = 0; run(5);
        rdy_val = 1; run(12);
        chk("t3_nbeats", rx.size(), 6);
        for (int i = 0; i < 6 && i < rx.size(); i++) begin
            chk("t3_data", rx[i].d, 32'hB0 + i);
            chk("t3_last", rx[i].l, i == 5);
        end

        // Arbiter attached, all channels requesting.
        new_test(); gmode = 1; arb_last = N - 1;
        for (int k = 0; k < N; k++) push_pkt(k, 2, DW'(k * 16), 0);
        run(20);
        chk("t2_nbeats", rx.size(), 8);
        if (rx.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("t2_order", rx[i].d, (i / 2) * 16 + (i % 2));
            chk("t2_span", rx[7].cyc - rx[0].cyc, 10);
        end
        chk("t2_yumi_cnt", yumi_cnt, 4);

        // Randomized traffic with valid gaps and random backpressure.
        new_test(); gmode = 1; gaps = 1; rnd_rdy = 1; sent = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0)
                push_pkt($urandom_range(0, N - 1), $urandom_range(1, 6), '0, 1);
            step();
        end
        gaps = 0; rnd_rdy = 0; rdy_val = 1;
        drained = 0;
        for (int c = 0; c < 600 && !drained; c++) begin
            step();
            drained = !m_busy && m_outq.size() == 0 && srcq[0].size() == 0 &&
                      srcq[1].size() == 0 && srcq[2].size() == 0 && srcq[3].size() == 0;
        end
        chk("rand_drained", drained, 1);
        chk("rand_nbeats", rx.size(), sent);
        chk("rand_err", err_o, 0);

        // 20-beat packet truncated at MAX_BEATS.
        new_test(); gmode = 0; gsel = 1;
        push_pkt(1, 20, 32'h100, 0);
        run(30);
        chk("t4_nbeats", rx.size(), 20);
        if (rx.size() == 20) begin
            chk("t4_last15", rx[15].l, 1);
            chk("t4_last14", rx[14].l, 0);
            chk("t4_last19", rx[19].l, 1);
            chk("t4_data16", rx[16].d, 32'h110);
        end
        chk("t4_err", err_o, 1);
        chk("t4_yumi_cnt", yumi_cnt, 2);

        // Reset in the middle of a packet.
        new_test(); gmode = 0; gsel = 3;
        push_pkt(3, 8, 32'hC0, 0);
        run(4);
        reset_i = 1'b1;
        #1;
        chk("t6_v_o", v_o, 0);
        chk("t6_ready_o", ready_o, 0);
        chk("t6_reqs_o", reqs_o, 0);
        chk("t6_err_o", err_o, 0);
        do_reset();
        new_test(); gmode = 0; gsel = 0;
        push_pkt(0, 3, 32'hD0, 0);
        run(8);
        chk("t6_nbeats", rx.size(), 3);
        for (int i = 0; i < 3 && i < rx.size(); i++) chk("t6_data", rx[i].d, 32'hD0 + i);

        // Illegal grants: not one-hot, then to an idle channel.
        new_test(); gmode = 2; graw = 4'b0011;
        push_pkt(0, 1, 32'hE0, 0);
        push_pkt(1, 1, 32'hE1, 0);
        run(4);
        chk("t5a_err", err_o, 1);
        chk("t5a_ready", ready_o, 0);
        chk("t5a_reqs", reqs_o, 4'b0011);
        do_reset();
        new_test(); gmode = 2; graw = 4'b0100;
        push_pkt(0, 1, 32'hE2, 0);
        run(3);
        chk("t5b_err", err_o, 1);
        chk("t5b_ready", ready_o, 0);
        chk("t5b_reqs", reqs_o, 4'b0001);
        chk("t5b_nbeats", rx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
